// File: rtl/key_pkg.sv
// Shared definitions for the key input path: click FSM states and the
// default double-click window, kept next to the debouncer timing constants.
package key_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } key_state_e;

    // 300 ms at 12 MHz
    localparam int unsigned KEY_WIN_NUM   = 32'd3600000;
    localparam int unsigned KEY_WIN_WIDTH = 32'd22;

endpackage

// File: rtl/key_click_fsm.sv
// Single-key click classifier: one press opens a window of WIN_NUM cycles;
// a second press inside it is a double click, silence until it closes is a
// single click. Both outputs are registered one-cycle strobes.
module key_click_fsm
    import key_pkg::*;
#(
    parameter int unsigned WIN_NUM = KEY_WIN_NUM,
    parameter int unsigned WIDTH   = KEY_WIN_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_pulse,
    output logic single_click,
    output logic double_click
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIN_NUM - 1);

    key_state_e       state;
    logic [WIDTH-1:0] cnt;

    // Click FSM with window counter; a press wins over window expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_pulse) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (key_pulse) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        single_click <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_click_decoder.sv
// Per-key click decoder: N independent click FSMs fed by the debouncer's
// key_pulse strobes.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int unsigned N       = 1,
    parameter int unsigned WIN_NUM = KEY_WIN_NUM,
    parameter int unsigned WIDTH   = KEY_WIN_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_pulse,
    output logic [N-1:0] single_click,
    output logic [N-1:0] double_click
);

    // One classifier per key; keys never interact
    for (genvar k = 0; k < N; k++) begin : g_key
        key_click_fsm #(
            .WIN_NUM (WIN_NUM),
            .WIDTH   (WIDTH)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_pulse    (key_pulse[k]),
            .single_click (single_click[k]),
            .double_click (double_click[k])
        );
    end

endmodule
